// File: rtl/dmem_responder.sv
// Data-memory responder for the two-stage RV32I pipeline: serves one load/store at a
// time after LATENCY wait states, with sb/sh/sw lane writes and sign/zero-extended loads.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_rd_en,
    input  logic        req_wr_en,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic [31:0] resp_rdata,
    output logic        resp_valid,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [2:0]     cnt_reg;
    logic           rd_reg;
    logic           wr_reg;
    logic [AW+1:0]  addr_reg;
    logic [31:0]    wdata_reg;
    logic [2:0]     size_reg;
    logic [31:0]    rdata_reg;
    logic           valid_reg;
    logic           err_reg;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           req_present;
    logic           accept;
    logic           access_fire;
    logic           use_live;
    logic           sel_rd;
    logic           sel_wr;
    logic [AW+1:0]  sel_addr;
    logic [31:0]    sel_wdata;
    logic [2:0]     sel_size;
    logic [AW-1:0]  word_idx;
    logic [1:0]     lane;
    logic           size_ok;
    logic           misaligned;
    logic           acc_err;
    logic           do_write;
    logic [3:0]     lane_we;
    logic [31:0]    lane_data;
    logic [31:0]    rd_word;
    logic [7:0]     rd_byte;
    logic [15:0]    rd_half;
    logic [31:0]    load_val;
    logic           addr_unused;

    assign req_present = req_rd_en | req_wr_en;
    assign accept      = (state_reg == IDLE) && req_present;
    assign addr_unused = ^req_addr[31:AW+2];

    // With zero wait states the access happens on the accept edge, so the live
    // request feeds the datapath; otherwise the captured copy does.
    assign use_live  = (state_reg == IDLE);
    assign sel_rd    = use_live ? req_rd_en : rd_reg;
    assign sel_wr    = use_live ? req_wr_en : wr_reg;
    assign sel_addr  = use_live ? req_addr[AW+1:0] : addr_reg;
    assign sel_wdata = use_live ? req_wdata : wdata_reg;
    assign sel_size  = use_live ? req_size : size_reg;

    assign access_fire = (LATENCY == 0) ? accept
                                        : ((state_reg == WAIT) && (cnt_reg == 3'd0));

    assign word_idx = sel_addr[AW+1:2];
    assign lane     = sel_addr[1:0];

    always_comb begin
        size_ok = 1'b0;
        case (sel_size)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_ok = 1'b1;
            default:                                size_ok = 1'b0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        case (sel_size[1:0])
            2'b01:   misaligned = sel_addr[0];
            2'b10:   misaligned = (sel_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign acc_err  = !size_ok || misaligned || (sel_rd && sel_wr);
    assign do_write = access_fire && sel_wr && !acc_err;

    // Store data is replicated into every lane so only the enables pick the target bytes.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign lane_we[gi] = (sel_size[1:0] == 2'b00) ? (lane == LANE) :
                             (sel_size[1:0] == 2'b01) ? (sel_addr[1] == LANE[1]) : 1'b1;
        assign lane_data[8*gi +: 8] = (sel_size[1:0] == 2'b00) ? sel_wdata[7:0] :
                                      (sel_size[1:0] == 2'b01) ? sel_wdata[8*(gi%2) +: 8] :
                                                                 sel_wdata[8*gi +: 8];
    end

    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[8*lane +: 8];
    assign rd_half = sel_addr[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        case (sel_size)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (do_write) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_we[l]) begin
                    mem[word_idx][8*l +: 8] <= lane_data[8*l +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_present) begin
                    state_next = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == 3'd0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg   <= 3'd0;
            rd_reg    <= 1'b0;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            size_reg  <= 3'd0;
            rdata_reg <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            valid_reg <= access_fire;
            err_reg   <= access_fire && acc_err;
            if (accept) begin
                rd_reg    <= req_rd_en;
                wr_reg    <= req_wr_en;
                addr_reg  <= req_addr[AW+1:0];
                wdata_reg <= req_wdata;
                size_reg  <= req_size;
                cnt_reg   <= CNT_INIT;
            end else if ((state_reg == WAIT) && (cnt_reg != 3'd0)) begin
                cnt_reg <= cnt_reg - 3'd1;
            end
            // Stores keep the previous load result; errors force it to zero.
            if (access_fire) begin
                if (acc_err) begin
                    rdata_reg <= '0;
                end else if (sel_rd) begin
                    rdata_reg <= load_val;
                end
            end
        end
    end

    assign busy       = accept || (state_reg == WAIT);
    assign resp_rdata = rdata_reg;
    assign resp_valid = valid_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none;
// every expected value below is hand-computed from the access and lane rules.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        target;

    logic [31:0] rdata_a, rdata_b;
    logic        valid_a, valid_b, busy_a, busy_b, err_a, err_b;

    int          n_vec = 0;
    int          n_bad = 0;
    int          valid_cnt_a = 0;
    logic [31:0] model_rdata [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .req_rd_en  (rd_en & ~target),
        .req_wr_en  (wr_en & ~target),
        .req_addr   (addr),
        .req_wdata  (wdata),
        .req_size   (size),
        .resp_rdata (rdata_a),
        .resp_valid (valid_a),
        .busy       (busy_a),
        .err        (err_a)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .req_rd_en  (rd_en & target),
        .req_wr_en  (wr_en & target),
        .req_addr   (addr),
        .req_wdata  (wdata),
        .req_size   (size),
        .resp_rdata (rdata_b),
        .resp_valid (valid_b),
        .busy       (busy_b),
        .err        (err_b)
    );

    always @(negedge clk) begin
        if (valid_a) valid_cnt_a <= valid_cnt_a + 1;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge while the selected DUT is in IDLE; returns
    // just after the rising edge that leaves RESP.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [31:0] a, input logic [31:0] wd, input logic [2:0] sz,
                              input logic [31:0] exp_data, input logic exp_err);
        int          lat;
        int          cyc;
        int          busy_cnt;
        logic        got_valid;
        logic [31:0] got_rdata;
        logic        got_err;
        logic [31:0] exp_r;
        lat       = target ? 0 : 2;
        cyc       = 0;
        busy_cnt  = 0;
        got_valid = 1'b0;
        got_rdata = '0;
        got_err   = 1'b0;
        rd_en = rd; wr_en = wr; addr = a; wdata = wd; size = sz;
        while (!got_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (target ? busy_b : busy_a) busy_cnt++;
            if (target ? valid_b : valid_a) begin
                got_valid = 1'b1;
                got_rdata = target ? rdata_b : rdata_a;
                got_err   = target ? err_b : err_a;
            end
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        if (exp_err)
            exp_r = 32'h0;
        else if (rd && !wr)
            exp_r = exp_data;
        else
            exp_r = model_rdata[target];
        model_rdata[target] = exp_r;
        check_value({tag, " cycles"}, 32'(cyc), 32'(lat + 2));
        check_value({tag, " busy"}, 32'(busy_cnt), 32'(lat + 1));
        check_value({tag, " err"}, {31'd0, got_err}, {31'd0, exp_err});
        check_value({tag, " rdata"}, got_rdata, exp_r);
        $display("txn %-10s dut=%0d rd=%0d wr=%0d addr=%h size=%b rdata=%h err=%0d cycles=%0d",
                 tag, target, rd, wr, a, sz, got_rdata, got_err, cyc);
    endtask

    initial begin
        int vcnt;
        reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; size = '0;
        target = 1'b0;
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_value("rst rdata", rdata_a, 32'h0);
        check_value("rst valid", {31'd0, valid_a}, 32'h0);
        check_value("rst err", {31'd0, err_a}, 32'h0);
        check_value("rst busy", {31'd0, busy_a}, 32'h0);
        @(posedge clk);
        #1;

        // Two-wait-state instance
        run_access("sw10", 0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0);
        run_access("lw10", 1, 0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0);
        run_access("sb13", 0, 1, 32'h13, 32'h00000080, 3'b000, 32'h0, 0);
        run_access("lb13", 1, 0, 32'h13, 32'h0, 3'b000, 32'hFFFFFF80, 0);
        run_access("lbu13", 1, 0, 32'h13, 32'h0, 3'b100, 32'h00000080, 0);
        run_access("lw10b", 1, 0, 32'h10, 32'h0, 3'b010, 32'h80ADBEEF, 0);
        run_access("sw10c", 0, 1, 32'h10, 32'h11111111, 3'b010, 32'h0, 0);
        run_access("sh12", 0, 1, 32'h12, 32'h00009234, 3'b001, 32'h0, 0);
        run_access("lw10c", 1, 0, 32'h10, 32'h0, 3'b010, 32'h92341111, 0);
        run_access("lh12", 1, 0, 32'h12, 32'h0, 3'b001, 32'hFFFF9234, 0);
        run_access("lhu12", 1, 0, 32'h12, 32'h0, 3'b101, 32'h00009234, 0);

        run_access("lw11err", 1, 0, 32'h11, 32'h0, 3'b010, 32'h0, 1);
        run_access("sh13err", 0, 1, 32'h13, 32'h0000FFFF, 3'b001, 32'h0, 1);
        run_access("lw10d", 1, 0, 32'h10, 32'h0, 3'b010, 32'h92341111, 0);
        run_access("sz011err", 0, 1, 32'h10, 32'h0, 3'b011, 32'h0, 1);
        run_access("lw10e", 1, 0, 32'h10, 32'h0, 3'b010, 32'h92341111, 0);
        run_access("rdwrerr", 1, 1, 32'h10, 32'h0, 3'b010, 32'h0, 1);
        run_access("lw10f", 1, 0, 32'h10, 32'h0, 3'b010, 32'h92341111, 0);

        // Reset lands on the access edge of a pending store
        vcnt  = valid_cnt_a;
        wr_en = 1'b1; addr = 32'h20; wdata = 32'h55; size = 3'b010;
        @(posedge clk);
        #1 wr_en = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_value("mid rdata", rdata_a, 32'h0);
        check_value("mid valid", {31'd0, valid_a}, 32'h0);
        check_value("mid err", {31'd0, err_a}, 32'h0);
        check_value("mid busy", {31'd0, busy_a}, 32'h0);
        repeat (3) @(negedge clk);
        check_value("mid no valid", 32'(valid_cnt_a), 32'(vcnt));
        model_rdata[0] = '0;
        model_rdata[1] = '0;
        @(posedge clk);
        #1;
        run_access("lw20", 1, 0, 32'h20, 32'h0, 3'b010, 32'h0, 0);
        run_access("lw10clr", 1, 0, 32'h10, 32'h0, 3'b010, 32'h0, 0);

        // Zero-wait-state instance with address wrap
        target = 1'b1;
        run_access("b sw404", 0, 1, 32'h404, 32'hA5A5A5A5, 3'b010, 32'h0, 0);
        run_access("b lw004", 1, 0, 32'h004, 32'h0, 3'b010, 32'hA5A5A5A5, 0);
        run_access("b lh406", 1, 0, 32'h406, 32'h0, 3'b001, 32'hFFFFA5A5, 0);
        run_access("b lw3err", 1, 0, 32'h003, 32'h0, 3'b010, 32'h0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
